// File: rtl/max_seq_ctrl.sv
// max_seq_ctrl: frames COUNT samples off a valid/ready stream and reports the max and its index.
// Define MAX_SEQ_MIN_TRACK_EN to also report the frame minimum and its index.
module max_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int COUNT  = 8,
    parameter int IDX_W  = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_out,
    output logic [IDX_W-1:0]  max_idx,
`ifdef MAX_SEQ_MIN_TRACK_EN
    output logic [DATA_W-1:0] min_out,
    output logic [IDX_W-1:0]  min_idx,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(COUNT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W:0]    r_count;
    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic              w_xfer;
    logic              w_first;
    logic              w_last;
    logic              w_gt;

    // clr wins over a transfer, so a sample offered alongside it is never taken
    assign w_xfer  = (r_state == S_COLLECT) && in_valid && !clr;
    assign w_first = (r_count == '0);
    assign w_last  = (r_count == LAST);
    assign w_gt    = (in_data > r_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_COLLECT;
                end
                S_COLLECT: begin
                    if (w_xfer && w_last) w_next = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            S_COLLECT: begin
                in_ready = !clr;
                busy     = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // count==0 doubles as the "running max empty" marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_max   <= '0;
            r_idx   <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_count <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
            if (w_first || w_gt) begin
                r_max <= in_data;
                r_idx <= r_count[IDX_W-1:0];
            end
        end
    end

    assign max_out = r_max;
    assign max_idx = r_idx;

`ifdef MAX_SEQ_MIN_TRACK_EN
    logic [DATA_W-1:0] r_min;
    logic [IDX_W-1:0]  r_midx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min  <= '0;
            r_midx <= '0;
        end else if (w_xfer && (w_first || (in_data < r_min))) begin
            r_min  <= in_data;
            r_midx <= r_count[IDX_W-1:0];
        end
    end

    assign min_out = r_min;
    assign min_idx = r_midx;
`else
`endif

endmodule

// File: tb/tb_max_seq_ctrl.sv
// Bench for max_seq_ctrl: frame vector table, corner sequences and a
// randomized run checked against a frame-level reference model.
module tb_max_seq_ctrl;

    localparam int DW  = 4;
    localparam int CNT = 8;
    localparam int IW  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] max_out;
    logic [IW-1:0] max_idx;
    logic          busy;
`ifdef MAX_SEQ_MIN_TRACK_EN
    logic [DW-1:0] min_out;
    logic [IW-1:0] min_idx;
`endif

    max_seq_ctrl #(
        .DATA_W(DW),
        .COUNT (CNT),
        .IDX_W (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .max_out  (max_out),
        .max_idx  (max_idx),
`ifdef MAX_SEQ_MIN_TRACK_EN
        .min_out  (min_out),
        .min_idx  (min_idx),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] s [CNT];
        bit            bub;
        logic [DW-1:0] emax;
        int            eidx;
        logic [DW-1:0] emin;
        int            emidx;
        int            ecyc;
    } vec_t;

    vec_t vt [4];

    int n_cmp = 0;
    int n_err = 0;

    // reference model: 0 idle, 1 collecting, 2 result held
    int            ph;
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_max;
    logic [DW-1:0] m_min;
    int            m_idx;
    int            m_midx;
    bit            m_known;
    int            rdy_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph      = 0;
        q.delete();
        m_max   = '0;
        m_min   = '0;
        m_idx   = 0;
        m_midx  = 0;
        m_known = 1'b1;
    endtask

    task automatic model_frame();
        m_max  = q[0];
        m_min  = q[0];
        m_idx  = 0;
        m_midx = 0;
        for (int i = 1; i < CNT; i++) begin
            if (q[i] > m_max) begin
                m_max = q[i];
                m_idx = i;
            end
            if (q[i] < m_min) begin
                m_min  = q[i];
                m_midx = i;
            end
        end
    endtask

    task automatic model_edge(input bit a_s, input bit a_c, input bit a_v,
                              input logic [DW-1:0] a_d, input bit a_r);
        if (a_c) begin
            ph = 0;
        end else begin
            case (ph)
                0: if (a_s) begin
                    ph      = 1;
                    q.delete();
                    m_known = 1'b0;
                end
                1: if (a_v) begin
                    q.push_back(a_d);
                    if (q.size() == CNT) begin
                        model_frame();
                        ph      = 2;
                        m_known = 1'b1;
                    end
                end
                default: if (a_r) ph = 0;
            endcase
        end
    endtask

    task automatic check_outs(input bit a_c);
        chk("in_ready", in_ready, (ph == 1 && !a_c));
        chk("out_valid", out_valid, ph == 2);
        chk("busy", busy, ph != 0);
        if (m_known) begin
            chk("max_out", max_out, m_max);
            chk("max_idx", max_idx, m_idx);
`ifdef MAX_SEQ_MIN_TRACK_EN
            chk("min_out", min_out, m_min);
            chk("min_idx", min_idx, m_midx);
`endif
        end
        if (in_ready) rdy_cnt++;
    endtask

    // call just after a rising edge; returns just after the next one
    task automatic step(input bit a_s, input bit a_c, input bit a_v,
                        input logic [DW-1:0] a_d, input bit a_r);
        start     = a_s;
        clr       = a_c;
        in_valid  = a_v;
        in_data   = a_d;
        out_ready = a_r;
        @(negedge clk);
        check_outs(a_c);
        @(posedge clk);
        model_edge(a_s, a_c, a_v, a_d, a_r);
        #1;
    endtask

    task automatic hard_reset();
        start     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst max_out", max_out, 0);
        chk("rst max_idx", max_idx, 0);
`ifdef MAX_SEQ_MIN_TRACK_EN
        chk("rst min_out", min_out, 0);
        chk("rst min_idx", min_idx, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic run_vec(input int k, input int hold);
        step(1, 0, 0, '0, 0);
        rdy_cnt = 0;
        for (int i = 0; i < CNT; i++) begin
            if (vt[k].bub) step(0, 0, 0, DW'($urandom), 0);
            step(0, 0, 1, vt[k].s[i], 0);
        end
        chk("collect_cycles", rdy_cnt, vt[k].ecyc);
        chk("vec out_valid", out_valid, 1);
        chk("vec max_out", max_out, vt[k].emax);
        chk("vec max_idx", max_idx, vt[k].eidx);
`ifdef MAX_SEQ_MIN_TRACK_EN
        chk("vec min_out", min_out, vt[k].emin);
        chk("vec min_idx", min_idx, vt[k].emidx);
`endif
        // stalled hand-off with stray samples and a start pulse
        for (int j = 0; j < hold; j++) begin
            step(j == hold / 2, 0, (j % 2) == 1, DW'($urandom), 0);
        end
        chk("hold max_out", max_out, vt[k].emax);
        step(0, 0, 0, '0, 1);
    endtask

    initial begin
        vt[0] = '{'{4'd3, 4'd9, 4'd1, 4'd9, 4'd15, 4'd0, 4'd7, 4'd2},
                  1'b0, 4'd15, 4, 4'd0, 5, 8};
        vt[1] = '{'{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5},
                  1'b1, 4'd5, 0, 4'd5, 0, 16};
        vt[2] = '{'{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7},
                  1'b0, 4'd7, 7, 4'd0, 0, 8};
        vt[3] = '{'{4'd6, 4'd2, 4'd9, 4'd2, 4'd14, 4'd1, 4'd1, 4'd3},
                  1'b0, 4'd14, 4, 4'd1, 5, 8};

        rst_n     = 1'b1;
        start     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        hard_reset();

        // reset in the middle of a frame, then a clean frame
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 4'd11, 0);
        step(0, 0, 1, 4'd13, 0);
        step(0, 0, 1, 4'd2, 0);
        hard_reset();
        run_vec(0, 2);

        run_vec(1, 1);
        run_vec(3, 10);
        run_vec(0, 1);

        // abort after 4 samples; clr also beats a sample offered with it
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 4'd4, 0);
        step(0, 0, 1, 4'd12, 0);
        step(0, 0, 1, 4'd3, 0);
        step(0, 0, 1, 4'd8, 0);
        step(0, 1, 1, 4'd15, 0);
        step(0, 0, 1, 4'd15, 0);
        run_vec(2, 1);

        // clr wins over start in idle
        step(1, 1, 0, '0, 0);
        step(0, 0, 1, 4'd9, 0);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 4) == 0, ($urandom % 60) == 0,
                 ($urandom % 3) != 0, DW'($urandom), ($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
